imem_loader: RTL
================

Name: imem_loader

Overview:
- Boot-time writer for the instruction memory's write port (wr_addr0/wr_din0/we0).
- Accepts a byte stream (valid/ready) from a host link such as a UART receiver.
- Assembles little-endian 32-bit words and writes them sequentially from BASE_ADDR.
- Asserts core_hold so the core stays stalled until the image is fully loaded.

Parameters:
- DEPTH, 256, instruction memory depth in 32-bit words; maximum accepted word count.
- BASE_ADDR, 32'h0000_0000, byte address of the first written word; must be word-aligned.

Ports:
- clk  input  1  clock, all logic on rising edge
- rst  input  1  synchronous, active-low reset; sampled on rising clk edge, 0 = reset
- start  input  1  single-cycle pulse; begins a load session
- byte_in  input  8  stream data byte
- byte_valid  input  1  byte_in is valid
- byte_ready  output  1  loader accepts a byte this cycle
- wr_addr0  output  32  byte write address to instruction memory
- wr_din0  output  32  write data to instruction memory
- we0  output  1  write enable, one cycle per word
- core_hold  output  1  high from start until done; keeps the core stalled
- busy  output  1  session in progress
- done  output  1  sticky; load finished
- err  output  1  sticky; length overflow or checksum failure

Behaviour:
- All outputs are registered.
- Reset values (rst=0): state=IDLE, byte_ready=0, we0=0, wr_addr0=0, wr_din0=0, core_hold=1, busy=0, done=0, err=0.
- A byte is accepted only when byte_valid && byte_ready; no transfer happens on any other cycle.
- Stream format: LEN_LO, LEN_HI (16-bit word count N, little-endian), then 4*N data bytes, byte0 = bits [7:0].
- FSM states: IDLE, LEN_LO, LEN_HI, DATA, WRITE, [CHK], DONE.
- IDLE: byte_ready=0. start=1 -> LEN_LO; clears done and err, sets busy=1, core_hold=1, word_idx=0, byte_idx=0.
- LEN_LO / LEN_HI: byte_ready=1; capture the count bytes.
- LEN_HI exit rules:
  - N > DEPTH -> DONE with err=1; no writes issued.
  - N = 0 -> CHK if the checksum feature is compiled in, else DONE.
  - otherwise -> DATA.
- DATA: byte_ready=1; shift the byte into lane byte_idx. After the 4th byte -> WRITE; byte_ready drops on the following cycle.
- WRITE (exactly one cycle):
  - we0=1, wr_addr0=BASE_ADDR+(word_idx<<2), wr_din0=assembled word, byte_ready=0.
  - word_idx increments.
  - word_idx+1 == N -> CHK or DONE; else -> DATA.
- DONE: done=1, busy=0, core_hold=0, byte_ready=0. start -> new session (LEN_LO). start while busy is ignored.
- Latency: we0 is asserted on the cycle after the 4th byte of a word is accepted.
  - Sustained throughput: 1 word per 5 cycles.
- Stall gaps (byte_valid=0) are tolerated at any point with no state loss.
- Counter widths: word_idx is clog2(DEPTH)+1 bits. wr_addr0 is full 32-bit; the memory uses only the low bits.
- Reset mid-session: returns to IDLE immediately and the partial word is discarded. Words already written stay in memory. core_hold=1 until a full load completes.

Optional Feature:
- Macro: IMEM_LOADER_CHKSUM_EN.
- Defined:
  - A running 8-bit XOR of all data bytes is kept; LEN bytes are excluded.
  - After the last WRITE, or after LEN_HI when N=0, enter CHK with byte_ready=1.
  - Accept one checksum byte. Mismatch -> err=1. Then -> DONE.
- Undefined: the CHK state and XOR register do not exist; the stream ends after the last data byte.

Decomposition:
- Shared package imem_loader_pkg:
  - state enum encodings.
  - LEN_BYTES=2, WORD_BYTES=4.
  - default DEPTH/BASE_ADDR constants shared with the instruction memory instance.
- One natural sub-module: imem_word_packer, holding byte_idx, the lane shift register, and the word_ready pulse. The top module keeps the FSM, counters and write-port drive.

Test Plan:
- Basic load: start, bytes 02 00 13 00 00 00 93 00 10 00 -> we0 twice:
  - addr 0x0, data 0x00000013.
  - addr 0x4, data 0x00100093.
  - then done=1, core_hold=0.
- Empty image: start, bytes 00 00 -> no we0; done=1 within 2 cycles; err=0.
- Overflow: start, bytes 01 01 (N=257, DEPTH=256) -> no we0, done=1, err=1; further bytes not accepted (byte_ready=0).
- Backpressure: basic load with byte_valid low for 3 cycles between every byte -> identical writes and data; start pulses mid-session ignored.
- Reset mid-word: rst=0 after 2 data bytes of word 1 -> we0 never asserted for word 1. Next session writes from BASE_ADDR; core_hold stays 1 until done.
- Checksum (IMEM_LOADER_CHKSUM_EN):
  - 01 00 AA BB CC DD then 00 -> err=0.
  - same data with checksum 01 -> err=1, done=1.

Source files
------------

// File: rtl/imem_loader_pkg.sv
// Shared definitions for the instruction-memory boot loader.
// Optional macro IMEM_LOADER_CHKSUM_EN adds the trailing checksum state.
package imem_loader_pkg;

  localparam int          LEN_BYTES     = 2;
  localparam int          WORD_BYTES    = 4;
  localparam int          DEF_DEPTH     = 256;
  localparam logic [31:0] DEF_BASE_ADDR = 32'h0000_0000;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LEN_LO = 3'd1,
    ST_LEN_HI = 3'd2,
    ST_DATA   = 3'd3,
    ST_WRITE  = 3'd4,
`ifdef IMEM_LOADER_CHKSUM_EN
    ST_CHK    = 3'd5,
`endif
    ST_DONE   = 3'd6
  } state_e;

  // Byte address of word number idx relative to a word-aligned base.
  function automatic logic [31:0] word_addr(input logic [31:0] base,
                                            input logic [31:0] idx);
    return base + (idx << 2);
  endfunction

endpackage

// File: rtl/imem_word_packer.sv
// Little-endian byte-to-word packer for the instruction-memory loader.
// Lanes 0..WORD_BYTES-2 are stored; the final byte is combined directly into
// the output word so the loader can register the write on the same edge.
module imem_word_packer
  import imem_loader_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    clr,
  input  logic                    byte_fire,
  input  logic [7:0]              byte_in,
  output logic                    word_ready,
  output logic [8*WORD_BYTES-1:0] word
);

  localparam int IDX_W  = $clog2(WORD_BYTES);
  localparam int LANE_W = 8 * (WORD_BYTES - 1);

  logic [IDX_W-1:0]  byte_idx_q, byte_idx_d;
  logic [LANE_W-1:0] lanes_q, lanes_d;

  assign word_ready = byte_fire && (byte_idx_q == IDX_W'(WORD_BYTES - 1));
  assign word       = {byte_in, lanes_q};

  // Next lane contents and byte position within the current word.
  always_comb begin
    byte_idx_d = byte_idx_q;
    lanes_d    = lanes_q;
    if (clr) begin
      byte_idx_d = '0;
      lanes_d    = '0;
    end else if (byte_fire) begin
      byte_idx_d = byte_idx_q + IDX_W'(1);
      for (int i = 0; i < WORD_BYTES - 1; i++) begin
        if (byte_idx_q == IDX_W'(i)) lanes_d[i*8 +: 8] = byte_in;
      end
    end
  end

  // Lane and index registers; reset discards any partial word.
  always_ff @(posedge clk) begin
    if (!rst) begin
      byte_idx_q <= '0;
      lanes_q    <= '0;
    end else begin
      byte_idx_q <= byte_idx_d;
      lanes_q    <= lanes_d;
    end
  end

endmodule

// File: rtl/imem_loader.sv
// Boot-time instruction-memory loader: takes a length-prefixed byte stream,
// packs little-endian words and writes them sequentially from BASE_ADDR while
// holding the core stalled. Optional macro IMEM_LOADER_CHKSUM_EN appends an
// XOR checksum byte to the stream.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int          DEPTH     = DEF_DEPTH,
  parameter logic [31:0] BASE_ADDR = DEF_BASE_ADDR
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [7:0]  byte_in,
  input  logic        byte_valid,
  output logic        byte_ready,
  output logic [31:0] wr_addr0,
  output logic [31:0] wr_din0,
  output logic        we0,
  output logic        core_hold,
  output logic        busy,
  output logic        done,
  output logic        err
);

  localparam int          IDX_W   = $clog2(DEPTH) + 1;
  localparam int          LEN_W   = 8 * LEN_BYTES;
  localparam logic [31:0] DEPTH_U = 32'(DEPTH);

  state_e             state_q, state_d;
  logic [LEN_W-1:0]   len_q, len_d;
  logic [IDX_W-1:0]   word_idx_q, word_idx_d;
  logic               byte_ready_q, byte_ready_d;
  logic               we0_q, we0_d;
  logic [31:0]        wr_addr0_q, wr_addr0_d;
  logic [31:0]        wr_din0_q, wr_din0_d;
  logic               core_hold_q, core_hold_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               err_q, err_d;
`ifdef IMEM_LOADER_CHKSUM_EN
  logic [7:0]         xor_q, xor_d;
`endif

  logic               fire;
  logic               pack_clr;
  logic               word_ready;
  logic [31:0]        word;
  logic               to_tail;
  logic               to_done;

  assign fire = byte_valid && byte_ready_q;

  imem_word_packer u_packer (
    .clk        (clk),
    .rst        (rst),
    .clr        (pack_clr),
    .byte_fire  (fire && (state_q == ST_DATA)),
    .byte_in    (byte_in),
    .word_ready (word_ready),
    .word       (word)
  );

  // Next-state and registered-output logic for the load session.
  always_comb begin
    state_d     = state_q;
    len_d       = len_q;
    word_idx_d  = word_idx_q;
    we0_d       = 1'b0;
    wr_addr0_d  = wr_addr0_q;
    wr_din0_d   = wr_din0_q;
    core_hold_d = core_hold_q;
    busy_d      = busy_q;
    done_d      = done_q;
    err_d       = err_q;
    pack_clr    = 1'b0;
    to_tail     = 1'b0;
    to_done     = 1'b0;
`ifdef IMEM_LOADER_CHKSUM_EN
    xor_d       = xor_q;
`endif

    unique case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          state_d     = ST_LEN_LO;
          done_d      = 1'b0;
          err_d       = 1'b0;
          busy_d      = 1'b1;
          core_hold_d = 1'b1;
          word_idx_d  = '0;
          len_d       = '0;
          pack_clr    = 1'b1;
`ifdef IMEM_LOADER_CHKSUM_EN
          xor_d       = 8'h00;
`endif
        end
      end
      ST_LEN_LO: begin
        if (fire) begin
          len_d   = LEN_W'(byte_in);
          state_d = ST_LEN_HI;
        end
      end
      ST_LEN_HI: begin
        if (fire) begin
          len_d = {byte_in, len_q[7:0]};
          if (32'(len_d) > DEPTH_U) begin
            err_d   = 1'b1;
            to_done = 1'b1;
          end else if (len_d == '0) begin
            to_tail = 1'b1;
          end else begin
            state_d = ST_DATA;
          end
        end
      end
      ST_DATA: begin
`ifdef IMEM_LOADER_CHKSUM_EN
        if (fire) xor_d = xor_q ^ byte_in;
`endif
        if (word_ready) begin
          we0_d      = 1'b1;
          wr_addr0_d = word_addr(BASE_ADDR, 32'(word_idx_q));
          wr_din0_d  = word;
          state_d    = ST_WRITE;
        end
      end
      ST_WRITE: begin
        word_idx_d = word_idx_q + IDX_W'(1);
        if ((32'(word_idx_q) + 32'd1) == 32'(len_q)) to_tail = 1'b1;
        else                                         state_d = ST_DATA;
      end
`ifdef IMEM_LOADER_CHKSUM_EN
      ST_CHK: begin
        if (fire) begin
          if (byte_in != xor_q) err_d = 1'b1;
          to_done = 1'b1;
        end
      end
`endif
      default: state_d = ST_IDLE;
    endcase

`ifdef IMEM_LOADER_CHKSUM_EN
    if (to_tail) state_d = ST_CHK;
`else
    if (to_tail) to_done = 1'b1;
`endif

    if (to_done) begin
      state_d     = ST_DONE;
      done_d      = 1'b1;
      busy_d      = 1'b0;
      core_hold_d = 1'b0;
    end

    unique case (state_d)
      ST_LEN_LO, ST_LEN_HI, ST_DATA: byte_ready_d = 1'b1;
`ifdef IMEM_LOADER_CHKSUM_EN
      ST_CHK:                        byte_ready_d = 1'b1;
`endif
      default:                       byte_ready_d = 1'b0;
    endcase
  end

  // State and output registers; reset abandons any session in flight.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= ST_IDLE;
      len_q        <= '0;
      word_idx_q   <= '0;
      byte_ready_q <= 1'b0;
      we0_q        <= 1'b0;
      wr_addr0_q   <= '0;
      wr_din0_q    <= '0;
      core_hold_q  <= 1'b1;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
`ifdef IMEM_LOADER_CHKSUM_EN
      xor_q        <= 8'h00;
`endif
    end else begin
      state_q      <= state_d;
      len_q        <= len_d;
      word_idx_q   <= word_idx_d;
      byte_ready_q <= byte_ready_d;
      we0_q        <= we0_d;
      wr_addr0_q   <= wr_addr0_d;
      wr_din0_q    <= wr_din0_d;
      core_hold_q  <= core_hold_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      err_q        <= err_d;
`ifdef IMEM_LOADER_CHKSUM_EN
      xor_q        <= xor_d;
`endif
    end
  end

  assign byte_ready = byte_ready_q;
  assign we0        = we0_q;
  assign wr_addr0   = wr_addr0_q;
  assign wr_din0    = wr_din0_q;
  assign core_hold  = core_hold_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign err        = err_q;

endmodule
